regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V pipeline. It succeeds the fixed 2-read/1-write file and adds:
- configurable width, depth and read/write port counts;
- single-edge operation with optional write-to-read bypass;
- a handshaked register-dump engine that replaces simulation-only printing.

It sits in the decode stage. Read ports feed ID/EX; write ports come from writeback and, optionally, a late-load return path.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; must be a power of 2, minimum 2
AW, $clog2(NREG), address width; derived localparam, not overridable
NRD, 2, number of read ports, 1..4
NWR, 1, number of write ports, 1..2
BYPASS, 1, 1 = a read sees a same-cycle write (write-first); 0 = read returns the pre-write value
SP_INIT, 32'h0000_01F4, reset value of x2
GP_INIT, 32'h1000_0000, reset value of x3

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
rs_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
rs_data  out  NRD*XLEN  registered read data; port k occupies bits [k*XLEN +: XLEN]
we  in  NWR  per-port write enable
wa  in  NWR*AW  write addresses, packed like rs_addr
wd  in  NWR*XLEN  write data, packed like rs_data
dump_start  in  1  one-cycle request to begin a register dump
dump_valid  out  1  dump_addr/dump_data are valid
dump_ready  in  1  consumer accepts the current dump beat
dump_addr  out  AW  index of the register being dumped
dump_data  out  XLEN  contents of register dump_addr
dump_busy  out  1  dump engine is active
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, asserts immediately, no clock needed):
  - x2 = SP_INIT, x3 = GP_INIT, all other registers = 0.
  - rs_data = 0; dump FSM goes to IDLE; dump_valid, dump_busy and dump_done = 0; dump index = 0.
  - Reset asserted mid-dump aborts the dump with no dump_done pulse.
- Register x0:
  - Writes to x0 are discarded.
  - Reads of x0 return 0, even when BYPASS=1 and a write to x0 occurs in the same cycle.
- Writes:
  - On the rising edge, for each port j with we[j]=1 and wa[j]!=0, the addressed register takes wd[j].
  - If both ports write the same address in one cycle, the higher-index port wins.
- Reads:
  - Latency is 1 cycle: rs_data[k] at edge n+1 reflects rs_addr[k] sampled at edge n.
  - BYPASS=1: if any write port targets rs_addr[k] in the sampling cycle, rs_data[k] takes that write data, using the same priority rule as writes.
  - BYPASS=0: rs_data[k] takes the array contents before that edge's write.
  - Every read port is independent; all ports may read the same address.
- Dump FSM, states IDLE, RUN, DONE:
  - IDLE: dump_valid = 0. If dump_start=1, the index is cleared to 0 and the FSM moves to RUN.
  - RUN: dump_valid = 1, dump_busy = 1, dump_addr = index, and dump_data is read combinationally from the array at index (current contents).
    - dump_valid=1 and dump_ready=0: dump_addr and dump_data hold; the FSM stays in RUN.
    - dump_valid=1 and dump_ready=1 at index < NREG-1: the index increments.
    - dump_valid=1 and dump_ready=1 at index = NREG-1: the FSM moves to DONE.
  - DONE: dump_done = 1 and dump_busy = 1 for exactly one cycle, then IDLE.
  - dump_start is ignored in RUN and DONE.
- Dump concurrency:
  - Writes are allowed during a dump. A write landing on the register currently presented updates dump_data from the next cycle.
  - The dump never stalls the read or write ports.
- Width rules: addresses are unsigned AW bits; there is no out-of-range case because NREG = 2^AW.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NREG;
  - named register indices REG_ZERO=0, REG_SP=2, REG_GP=3;
  - the dump FSM state enum (IDLE, RUN, DONE);
  - packed-port slice helper functions.
- One natural sub-module, regfile_dump_ctrl, contains the dump FSM and index counter. It drives the dump index to the top module and receives the array word back.
- The storage array, write priority and bypass muxing stay in the top module.

Test Plan:
- Reset values: assert rst with no clock running -> x2 reads 0x1F4, x3 reads 0x10000000, x1/x31 read 0, and rs_data=0 while rst is high.
- Bypass: NWR=1, BYPASS=1; write x5=0xDEADBEEF with rs_addr[0]=5 in the same cycle -> rs_data[0]=0xDEADBEEF on the next edge.
  - Same stimulus with BYPASS=0 -> old value 0, then 0xDEADBEEF one cycle later.
- x0 protection: write x0=0xFFFFFFFF while reading x0 on both ports -> both ports return 0 that cycle and all later cycles.
- Dual-write conflict: NWR=2; port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> x7=0x22, and the bypassed read also returns 0x22.
- Dump with back-pressure:
  - Pulse dump_start; hold dump_ready=0 for 3 cycles at index 4 -> dump_addr stays 4.
  - Then drive ready=1 continuously -> 32 beats total, in-order addresses 0..31, data matching the array.
  - dump_done pulses once, one cycle after beat 31 is accepted; dump_start pulsed during RUN is ignored.
- Reset mid-dump: assert rst at index 10 -> dump_valid and dump_busy drop immediately with no dump_done pulse; a fresh dump_start afterwards restarts at index 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port integer register file:
//   - default data width and register count
//   - named architectural register indices (zero, stack pointer, global pointer)
//   - dump engine state encoding
//   - helper for locating a port's lane inside a packed multi-port bus
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    // Low bit position of lane k in a bus made of equal lanes of width w.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Handshaked register-dump sequencer. Walks the register index 0..NREG-1,
// presenting one register per beat with valid/ready flow control, then emits a
// single-cycle done pulse.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   dump_start     one-cycle request; honoured only while idle
//   dump_ready     consumer accepts the current beat
//   dump_word      array contents at dump_index, supplied by the parent
//   dump_index     register index being presented (to the parent's array mux)
//   dump_valid     current beat valid
//   dump_addr      register index of the current beat
//   dump_data      register contents of the current beat (live array value)
//   dump_busy      engine active (RUN or DONE)
//   dump_done      one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_start,
    input  logic            dump_ready,
    input  logic [XLEN-1:0] dump_word,
    output logic [AW-1:0]   dump_index,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_addr,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy,
    output logic            dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    dump_state_t     state_reg;
    logic [AW-1:0]   index_reg;
    logic            valid_reg;
    logic            busy_reg;
    logic            done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            index_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (dump_start) begin
                        index_reg <= '0;
                        state_reg <= RUN;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    // valid is always high in RUN, so ready alone completes a beat
                    if (dump_ready) begin
                        if (index_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            index_reg <= index_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_index = index_reg;
    assign dump_addr  = index_reg;
    // Data is the live array word, so a write to the presented register shows
    // up on the following cycle without any extra logic here.
    assign dump_data  = dump_word;
    assign dump_valid = valid_reg;
    assign dump_busy  = busy_reg;
    assign dump_done  = done_reg;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file for the decode stage.
// x0 is hard-wired to zero; x2/x3 reset to SP_INIT/GP_INIT. Reads are
// registered (1-cycle latency) with optional write-first bypass. When several
// write ports hit the same register in one cycle the highest-index port wins.
// A dump engine streams every register out over a valid/ready interface
// without stalling the read or write ports.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rs_addr      NRD packed read addresses  (port k at [k*AW +: AW])
//   rs_data      NRD packed read data       (port k at [k*XLEN +: XLEN])
//   we, wa, wd   NWR write enables / packed addresses / packed data
//   dump_*       register dump handshake (see regfile_dump_ctrl)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int              XLEN    = XLEN_DEFAULT,
    parameter  int              NREG    = NREG_DEFAULT,
    parameter  int              NRD     = 2,
    parameter  int              NWR     = 1,
    parameter  bit              BYPASS  = 1'b1,
    parameter  logic [XLEN-1:0] SP_INIT = XLEN'(32'h0000_01F4),
    parameter  logic [XLEN-1:0] GP_INIT = XLEN'(32'h1000_0000),
    localparam int              AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rs_addr,
    output logic [NRD*XLEN-1:0]  rs_data,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 dump_start,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [AW-1:0]        dump_addr,
    output logic [XLEN-1:0]      dump_data,
    output logic                 dump_busy,
    output logic                 dump_done
);

    // Current architectural contents, one word per register (x0 constant 0).
    logic [XLEN-1:0] arr [NREG];
    logic [AW-1:0]   dump_index;

    genvar gi;

    // -------------------------------------------------------------------------
    // Storage: one flop word per register. Flops rather than block RAM because
    // x2/x3 need non-zero reset values and the dump path reads asynchronously.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == REG_ZERO) begin : g_zero
                assign arr[gi] = '0;
            end else begin : g_live
                localparam logic [XLEN-1:0] RST_VAL =
                    (gi == REG_SP) ? SP_INIT :
                    (gi == REG_GP) ? GP_INIT : '0;

                logic [XLEN-1:0] word_reg;
                logic [XLEN-1:0] word_next;

                // Ascending scan so the highest-index matching port overrides.
                always_comb begin
                    word_next = word_reg;
                    for (int j = 0; j < NWR; j++) begin
                        if (we[j] && (wa[lane_lo(j, AW) +: AW] == AW'(gi))) begin
                            word_next = wd[lane_lo(j, XLEN) +: XLEN];
                        end
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        word_reg <= RST_VAL;
                    end else begin
                        word_reg <= word_next;
                    end
                end

                assign arr[gi] = word_reg;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports: registered, independent, optional write-first bypass.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd_reg;
            logic [XLEN-1:0] rd_next;

            assign ra = rs_addr[gi*AW +: AW];

            always_comb begin
                rd_next = arr[ra];
                if (BYPASS) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (we[j] && (wa[lane_lo(j, AW) +: AW] == ra)) begin
                            rd_next = wd[lane_lo(j, XLEN) +: XLEN];
                        end
                    end
                end
                // Last word: x0 stays zero even if a same-cycle write targets it.
                if (ra == AW'(REG_ZERO)) begin
                    rd_next = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_reg <= '0;
                end else begin
                    rd_reg <= rd_next;
                end
            end

            assign rs_data[gi*XLEN +: XLEN] = rd_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Dump engine
    // -------------------------------------------------------------------------
    regfile_dump_ctrl #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_word  (arr[dump_index]),
        .dump_index (dump_index),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. A two-write-port bypassing instance carries
// the table-driven read/write vectors and the dump sequences; a single-write
// non-bypassing instance covers the read-before-write behaviour.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst     = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Main instance: NRD=2, NWR=2, BYPASS=1
    logic [2*AW-1:0]   rs_addr = '0;
    logic [2*XLEN-1:0] rs_data;
    logic [1:0]        we = '0;
    logic [2*AW-1:0]   wa = '0;
    logic [2*XLEN-1:0] wd = '0;
    logic              dump_start = 1'b0;
    logic              dump_ready = 1'b0;
    logic              dump_valid;
    logic [AW-1:0]     dump_addr;
    logic [XLEN-1:0]   dump_data;
    logic              dump_busy;
    logic              dump_done;

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rs_data(rs_data),
        .we(we), .wa(wa), .wd(wd),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    // Second instance: NRD=2, NWR=1, BYPASS=0
    logic [2*AW-1:0]   nb_rs_addr = '0;
    logic [2*XLEN-1:0] nb_rs_data;
    logic [0:0]        nb_we = '0;
    logic [AW-1:0]     nb_wa = '0;
    logic [XLEN-1:0]   nb_wd = '0;
    logic              nb_dump_valid;
    logic [AW-1:0]     nb_dump_addr;
    logic [XLEN-1:0]   nb_dump_data;
    logic              nb_dump_busy;
    logic              nb_dump_done;

    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(1), .BYPASS(1'b0)
    ) dut_nb (
        .clk(clk), .rst(rst),
        .rs_addr(nb_rs_addr), .rs_data(nb_rs_data),
        .we(nb_we), .wa(nb_wa), .wd(nb_wd),
        .dump_start(1'b0), .dump_valid(nb_dump_valid), .dump_ready(1'b0),
        .dump_addr(nb_dump_addr), .dump_data(nb_dump_data),
        .dump_busy(nb_dump_busy), .dump_done(nb_dump_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_regs [NREG];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int exp_addr;
        int stall;
        int done_cnt;
        bit w12;
        bit found;

        //              we     wa0  wa1  wd0            wd1           ra0  ra1  exp0           exp1
        vecs[0]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd2,  5'd3, 32'h0000_01F4, 32'h1000_0000};
        vecs[1]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd1,  5'd31, 32'h0,        32'h0};
        vecs[2]  = '{2'b01, 5'd5,  5'd0, 32'hDEAD_BEEF, 32'h0,        5'd5,  5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd5,  5'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{2'b01, 5'd0,  5'd0, 32'hFFFF_FFFF, 32'h0,        5'd0,  5'd0, 32'h0,         32'h0};
        vecs[5]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd0,  5'd0, 32'h0,         32'h0};
        vecs[6]  = '{2'b11, 5'd7,  5'd7, 32'h11,        32'h22,       5'd7,  5'd6, 32'h22,        32'h0};
        vecs[7]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd7,  5'd5, 32'h22,        32'hDEAD_BEEF};
        vecs[8]  = '{2'b11, 5'd8,  5'd9, 32'hAAAA,      32'h5555,     5'd9,  5'd8, 32'h5555,      32'hAAAA};
        vecs[9]  = '{2'b10, 5'd2,  5'd2, 32'h999,       32'h123,      5'd2,  5'd3, 32'h123,       32'h1000_0000};
        vecs[10] = '{2'b11, 5'd31, 5'd0, 32'hCAFE,      32'hBAD,      5'd31, 5'd0, 32'hCAFE,      32'h0};
        vecs[11] = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,        5'd31, 5'd9, 32'hCAFE,      32'h5555};

        // Expected array contents once the vectors above have been applied.
        for (int r = 0; r < NREG; r++) exp_regs[r] = 32'h0;
        exp_regs[2]  = 32'h123;
        exp_regs[3]  = 32'h1000_0000;
        exp_regs[5]  = 32'hDEAD_BEEF;
        exp_regs[7]  = 32'h22;
        exp_regs[8]  = 32'hAAAA;
        exp_regs[9]  = 32'h5555;
        exp_regs[31] = 32'hCAFE;

        // ---------------- reset with no clock running ----------------
        #1 rst = 1'b1;
        #10;
        check("rst_rs_data0", rs_data[31:0], 32'h0);
        check("rst_rs_data1", rs_data[63:32], 32'h0);
        check("rst_nb_rs_data0", nb_rs_data[31:0], 32'h0);
        check("rst_dump_valid", {31'b0, dump_valid}, 32'h0);
        check("rst_dump_busy", {31'b0, dump_busy}, 32'h0);
        check("rst_dump_done", {31'b0, dump_done}, 32'h0);
        $display("[TB] reset: rs_data=%h valid=%b busy=%b done=%b", rs_data, dump_valid, dump_busy, dump_done);

        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven read/write vectors ----------------
        for (int i = 0; i < 12; i++) begin
            we      = vecs[i].we;
            wa      = {vecs[i].wa1, vecs[i].wa0};
            wd      = {vecs[i].wd1, vecs[i].wd0};
            rs_addr = {vecs[i].ra1, vecs[i].ra0};
            @(negedge clk);
            check($sformatf("vec%0d_port0", i), rs_data[31:0], vecs[i].exp0);
            check($sformatf("vec%0d_port1", i), rs_data[63:32], vecs[i].exp1);
            $display("[TB] vec %0d: we=%b ra=%0d,%0d rd=%h,%h", i, vecs[i].we,
                     vecs[i].ra0, vecs[i].ra1, rs_data[31:0], rs_data[63:32]);
        end
        we = '0;

        // ---------------- non-bypass instance ----------------
        nb_we = 1'b1; nb_wa = 5'd5; nb_wd = 32'hDEAD_BEEF; nb_rs_addr = {5'd0, 5'd5};
        @(negedge clk);
        check("nb_same_cycle_old", nb_rs_data[31:0], 32'h0);
        $display("[TB] nb write x5, same-cycle read=%h", nb_rs_data[31:0]);
        nb_we = 1'b0; nb_rs_addr = {5'd5, 5'd5};
        @(negedge clk);
        check("nb_next_cycle0", nb_rs_data[31:0], 32'hDEAD_BEEF);
        check("nb_next_cycle1", nb_rs_data[63:32], 32'hDEAD_BEEF);
        $display("[TB] nb read x5=%h,%h", nb_rs_data[31:0], nb_rs_data[63:32]);
        nb_we = 1'b1; nb_wa = 5'd0; nb_wd = 32'hFFFF_FFFF; nb_rs_addr = {5'd0, 5'd0};
        @(negedge clk);
        nb_we = 1'b0;
        check("nb_x0_write0", nb_rs_data[31:0], 32'h0);
        @(negedge clk);
        check("nb_x0_later", nb_rs_data[63:32], 32'h0);
        $display("[TB] nb x0 read=%h", nb_rs_data[63:32]);

        // ---------------- dump with back-pressure ----------------
        dump_start = 1'b1; dump_ready = 1'b0;
        @(negedge clk);
        dump_start = 1'b0;
        beats = 0; exp_addr = 0; stall = 0; done_cnt = 0; w12 = 1'b0;
        for (int cyc = 0; cyc < 200 && beats < 32; cyc++) begin
            we = '0;
            dump_start = 1'b0;
            if (dump_done) done_cnt++;
            check($sformatf("dump_valid_%0d", exp_addr), {31'b0, dump_valid}, 32'h1);
            check($sformatf("dump_busy_%0d", exp_addr), {31'b0, dump_busy}, 32'h1);
            check($sformatf("dump_addr_%0d", exp_addr), {27'b0, dump_addr}, exp_addr);
            check($sformatf("dump_data_%0d", exp_addr), dump_data, exp_regs[exp_addr]);
            if (exp_addr == 4 && stall < 3) begin
                dump_ready = 1'b0;
                stall++;
            end else if (exp_addr == 12 && !w12) begin
                // write the presented register while stalled
                dump_ready = 1'b0;
                we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'h1212};
                exp_regs[12] = 32'h1212;
                w12 = 1'b1;
            end else begin
                dump_ready = 1'b1;
                if (exp_addr == 10) dump_start = 1'b1;
            end
            $display("[TB] dump beat addr=%0d data=%h ready=%b", dump_addr, dump_data, dump_ready);
            if (dump_ready) begin
                beats++;
                if (exp_addr < 31) exp_addr++;
            end
            @(negedge clk);
        end
        dump_ready = 1'b0;
        dump_start = 1'b0;
        we = '0;
        check("dump_beats", beats, 32);
        check("dump_no_early_done", done_cnt, 0);
        check("dump_done_pulse", {31'b0, dump_done}, 32'h1);
        check("dump_valid_in_done", {31'b0, dump_valid}, 32'h0);
        check("dump_busy_in_done", {31'b0, dump_busy}, 32'h1);
        $display("[TB] dump end: beats=%0d done=%b busy=%b", beats, dump_done, dump_busy);
        @(negedge clk);
        check("dump_done_one_cycle", {31'b0, dump_done}, 32'h0);
        check("dump_busy_after", {31'b0, dump_busy}, 32'h0);

        // ---------------- reset mid-dump ----------------
        dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dump_valid && dump_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_index10", {31'b0, found}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, dump_valid}, 32'h0);
        check("midrst_busy", {31'b0, dump_busy}, 32'h0);
        check("midrst_done", {31'b0, dump_done}, 32'h0);
        check("midrst_rs_data", rs_data[31:0], 32'h0);
        $display("[TB] mid-dump reset: valid=%b busy=%b done=%b", dump_valid, dump_busy, dump_done);
        @(negedge clk);
        check("midrst_done_held", {31'b0, dump_done}, 32'h0);
        rst = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);
        check("postrst_done", {31'b0, dump_done}, 32'h0);
        check("postrst_idle", {31'b0, dump_valid}, 32'h0);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        check("restart_addr0", {27'b0, dump_addr}, 32'd0);
        check("restart_data0", dump_data, 32'h0);
        dump_ready = 1'b1;
        @(negedge clk);
        check("restart_addr1", {27'b0, dump_addr}, 32'd1);
        @(negedge clk);
        check("restart_addr2", {27'b0, dump_addr}, 32'd2);
        check("restart_sp", dump_data, 32'h0000_01F4);
        @(negedge clk);
        check("restart_gp", dump_data, 32'h1000_0000);
        $display("[TB] restart dump addr=%0d data=%h", dump_addr, dump_data);
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dump_done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("restart_completes", {31'b0, found}, 32'h1);
        dump_ready = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
